// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared configuration for the fetch stage and the later pipeline stages.
//   The `defines mirror the project-wide configs.v values (widths, jump
//   opcode, nop word) so decode and hazard logic can reuse them unchanged.
//   The package adds typed constants and the jump-detect helper.
// ----------------------------------------------------------------------------
`ifndef FETCH_UNIT_CONFIGS_DEFINED
`define FETCH_UNIT_CONFIGS_DEFINED
`define ADDRESS_LEN 26
`define WORD_LEN    32
`define OPC_J       6'b000010
`define NOP_WORD    32'h0000_0000
`endif

package fetch_unit_pkg;

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The primary opcode lives in bits [31:26] of every MIPS instruction word.
    function automatic logic is_jump(input logic [31:0] inst);
        return inst[31:26] == `OPC_J;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// ----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register holding {inst, pc_plus1, valid}. Template for the
//   later pipeline registers.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     i_hold             keep current contents (stall)
//     i_clear            load a bubble; wins over i_hold
//     i_inst/i_pc_plus1/i_valid   next contents on a normal load
//     o_inst/o_pc_plus1/o_valid   registered contents
// ----------------------------------------------------------------------------
module if_id_reg #(
    parameter int unsigned ADDR_W = `ADDRESS_LEN,
    parameter int unsigned DATA_W = `WORD_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_hold,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_pc_plus1,
    input  logic              i_valid,
    output logic [DATA_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_pc_plus1,
    output logic              o_valid
);

    logic [DATA_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_pc_plus1;
    logic              r_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the reset branch is in the sensitivity list
    // so it acts without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inst     <= DATA_W'(`NOP_WORD);
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (i_clear) begin
            r_inst     <= DATA_W'(`NOP_WORD);
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_hold) begin
            r_inst     <= i_inst;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= i_valid;
        end
    end

    assign o_inst     = r_inst;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//   MIPS instruction-fetch stage: PC register, next-PC selection (redirect,
//   stall, early unconditional jump, sequential), fetch counter, and the
//   IF/ID register feeding decode.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     imem_adr        word address to instruction memory (= PC)
//     imem_inst       combinational instruction word for imem_adr
//     stall           hold PC, IF/ID and counter
//     redirect        taken branch from ID; overrides stall
//     redirect_pc     branch target word address
//     id_inst, id_pc_plus1, id_valid   IF/ID contents
//     fetch_cnt       saturating count of instructions loaded into IF/ID
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned ADDR_W   = `ADDRESS_LEN,
    parameter int unsigned DATA_W   = `WORD_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_adr,
    input  logic [DATA_W-1:0] imem_inst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] id_inst,
    output logic [ADDR_W-1:0] id_pc_plus1,
    output logic              id_valid,
    output logic [CNT_W-1:0]  fetch_cnt
);

    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_fetch_cnt;

    logic [ADDR_W-1:0] w_pc_plus1;
    logic              w_is_jump;
    logic [ADDR_W-1:0] w_jump_target;
    logic [ADDR_W-1:0] w_next_pc;
    logic              w_load;
    logic              w_unused_inst;

    // Sequential address wraps naturally at ADDR_W bits.
    assign w_pc_plus1    = r_pc + ADDR_W'(1);
    assign w_is_jump     = is_jump(imem_inst);
    assign w_jump_target = imem_inst[ADDR_W-1:0];
    assign w_load        = !redirect && !stall;
    // Instruction bits between the target field and the opcode are decode's.
    assign w_unused_inst = ^imem_inst;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next_pc = w_pc_plus1;
        if (redirect) begin
            w_next_pc = redirect_pc;
        end else if (stall) begin
            w_next_pc = r_pc;
        end else if (w_is_jump) begin
            w_next_pc = w_jump_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Counts words loaded into IF/ID; jumps count, bubbles and stalls do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_cnt <= '0;
        end else if (w_load && (r_fetch_cnt != CNT_MAX)) begin
            r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
        end
    end

    if_id_reg #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_hold     (stall),
        .i_clear    (redirect),
        .i_inst     (imem_inst),
        .i_pc_plus1 (w_pc_plus1),
        .i_valid    (1'b1),
        .o_inst     (id_inst),
        .o_pc_plus1 (id_pc_plus1),
        .o_valid    (id_valid)
    );

    assign imem_adr  = r_pc;
    assign fetch_cnt = r_fetch_cnt;

endmodule
